// File: rtl/ram1clk1ino.sv
// Single-clock byte-writable RAM, one write port, RDCNT write-first read ports, with a clear sweep.
// Read latency 1 cycle; rdy_o low during reset and during a sweep, when writes are dropped and reads return 0.
module ram1clk1ino #(
  parameter int             SZ       = 2,
  parameter int             DW       = 32,
  parameter int             RDCNT    = 2,
  parameter logic [DW-1:0]  CLRVAL   = '0,
  parameter bit             CLRONRST = 1'b1,
  parameter string          SRCFILE  = "",
  localparam int            AW       = (SZ > 1) ? $clog2(SZ) : 1,
  localparam int            SW       = DW / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  output logic                  rdy_o,
  input  logic                  we_i,
  input  logic [SW-1:0]         sel_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DW-1:0]         i,
  input  logic [RDCNT*AW-1:0]   raddr_i,
  output logic [RDCNT*DW-1:0]   o
);

  typedef enum logic {IDLE, CLR} state_t;

  localparam logic [AW:0] SZ_W = SZ[AW:0];
  localparam logic [AW:0] LAST = SZ_W - 1'b1;

  logic [DW-1:0]        r_mem [SZ];
  state_t               r_state;
  logic [AW:0]          r_cnt;
  logic                 r_rdy;
  logic [RDCNT*DW-1:0]  r_o;

  logic                 w_acc;
  logic                 w_wen;
  logic [DW-1:0]        w_mask;
  logic [DW-1:0]        w_merged;
  logic [RDCNT*DW-1:0]  w_rd;

  assign w_acc = (r_state == IDLE) && r_rdy;
  assign w_wen = w_acc && we_i && ({1'b0, waddr_i} < SZ_W) && (|sel_i);

  for (genvar b = 0; b < SW; b++) begin : g_mask
    assign w_mask[b*8 +: 8] = {8{sel_i[b]}};
  end

  // Post-write word: also the bypass value for same-address reads.
  assign w_merged = (r_mem[waddr_i] & ~w_mask) | (i & w_mask);

  for (genvar k = 0; k < RDCNT; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = raddr_i[k*AW +: AW];
    assign w_rd[k*DW +: DW] = ({1'b0, w_ra} >= SZ_W)            ? '0 :
                              (w_wen && (w_ra == waddr_i))      ? w_merged :
                                                                  r_mem[w_ra];
  end

  always_ff @(posedge clk_i) begin
    if (w_wen) begin
      r_mem[waddr_i] <= w_merged;
    end else if (r_state == CLR) begin
      r_mem[r_cnt[AW-1:0]] <= CLRVAL;
    end
  end

  // IDLE with r_rdy low only occurs on the first edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
      r_cnt   <= '0;
      r_o     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_rdy) begin
            r_o <= '0;
            if (CLRONRST) begin
              r_state <= CLR;
              r_cnt   <= '0;
            end else begin
              r_rdy <= 1'b1;
            end
          end else if (clr_i) begin
            r_state <= CLR;
            r_rdy   <= 1'b0;
            r_cnt   <= '0;
            r_o     <= '0;
          end else begin
            r_o <= w_rd;
          end
        end
        CLR: begin
          r_o <= '0;
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_rdy   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b0;
          r_cnt   <= '0;
          r_o     <= '0;
        end
      endcase
    end
  end

  assign rdy_o = r_rdy;
  assign o     = r_o;

endmodule

// File: tb/tb_ram1clk1ino.sv
// Bench for ram1clk1ino: SZ=8 instance with A5A5A5A5 clear value, plus an SZ=6 instance for out-of-range access.
module tb_ram1clk1ino;
  localparam int AW = 3;
  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, we = 1'b0;
  logic        rdy;
  logic [3:0]  sel = '0;
  logic [2:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [5:0]  ra = '0;
  logic [63:0] o;

  logic        rdy6, we6 = 1'b0;
  logic [3:0]  sel6 = '0;
  logic [2:0]  wa6 = '0;
  logic [31:0] wd6 = '0;
  logic [5:0]  ra6 = '0;
  logic [63:0] o6;

  logic [31:0] mdl  [8];
  logic [31:0] mdl6 [6];
  logic [63:0] sb_q [$];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  ram1clk1ino #(.SZ(8), .DW(32), .RDCNT(2), .CLRVAL(CV), .CLRONRST(1'b1), .SRCFILE("")) u_dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .rdy_o(rdy), .we_i(we), .sel_i(sel),
    .waddr_i(wa), .i(wd), .raddr_i(ra), .o(o));

  ram1clk1ino #(.SZ(6), .DW(32), .RDCNT(2), .CLRVAL(32'h0), .CLRONRST(1'b1), .SRCFILE("")) u_dut6 (
    .clk_i(clk), .rst_i(rst), .clr_i(1'b0), .rdy_o(rdy6), .we_i(we6), .sel_i(sel6),
    .waddr_i(wa6), .i(wd6), .raddr_i(ra6), .o(o6));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] s);
    merge = old;
    for (int b = 0; b < 4; b++) if (s[b]) merge[b*8 +: 8] = din[b*8 +: 8];
  endfunction

  task automatic cyc(input string tag, input logic w, input logic [3:0] s, input int a,
                     input logic [31:0] d, input int r0, input int r1);
    logic [63:0] e;
    @(negedge clk);
    we = w; sel = s; wa = a[AW-1:0]; wd = d; ra = {r1[AW-1:0], r0[AW-1:0]};
    if (w) mdl[a] = merge(mdl[a], d, s);
    sb_q.push_back({mdl[r1], mdl[r0]});
    @(posedge clk); #1;
    we = 1'b0;
    e = sb_q.pop_front();
    chk(tag, o, e);
  endtask

  task automatic cyc6(input string tag, input logic w, input logic [3:0] s, input int a,
                      input logic [31:0] d, input int r0, input int r1);
    logic [63:0] e;
    @(negedge clk);
    we6 = w; sel6 = s; wa6 = a[2:0]; wd6 = d; ra6 = {r1[2:0], r0[2:0]};
    if (w && a < 6) mdl6[a] = merge(mdl6[a], d, s);
    sb_q.push_back({(r1 < 6) ? mdl6[r1] : 32'h0, (r0 < 6) ? mdl6[r0] : 32'h0});
    @(posedge clk); #1;
    we6 = 1'b0;
    e = sb_q.pop_front();
    chk(tag, o6, e);
  endtask

  task automatic reset_sweep(input string tag);
    int n = 0, n6 = 0;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (!rdy) n++;
      if (!rdy6) n6++;
      if (rdy && rdy6) break;
    end
    chk({tag, "_len8"}, n, 8);
    chk({tag, "_len6"}, n6, 6);
    for (int k = 0; k < 8; k++) mdl[k] = CV;
    for (int k = 0; k < 6; k++) mdl6[k] = 32'h0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 8; a++) cyc(tag, 1'b0, 4'h0, 0, 32'h0, a, 7 - a);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_o", o, 64'h0);
    chk("rst_o6", o6, 64'h0);
    reset_sweep("init");
    read_all("init_rd");

    cyc("w3_zero", 1'b1, 4'hF, 3, 32'h0, 0, 0);
    cyc("w3_part", 1'b1, 4'b0101, 3, 32'h11223344, 0, 0);
    cyc("rd3", 1'b0, 4'h0, 0, 32'h0, 3, 3);
    chk("rd3_const", o[31:0], 32'h00220044);
    cyc("wf5", 1'b1, 4'hF, 5, 32'hDEADBEEF, 5, 5);
    chk("wf5_const", o, {32'hDEADBEEF, 32'hDEADBEEF});
    cyc("wf5_part", 1'b1, 4'b0011, 5, 32'h0, 5, 2);
    cyc("sel0", 1'b1, 4'h0, 2, 32'hFFFFFFFF, 2, 2);
    for (int k = 0; k < 40; k++)
      cyc("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 7),
          $urandom, $urandom_range(0, 7), $urandom_range(0, 7));
    read_all("rand_rd");

    for (int a = 0; a < 6; a++) cyc6("w6", 1'b1, 4'hF, a, 32'h100 + a, 0, 0);
    cyc6("oor_wf", 1'b1, 4'hF, 7, 32'hFFFFFFFF, 7, 6);
    for (int a = 0; a < 6; a++) cyc6("oor_rd", 1'b0, 4'h0, 0, 32'h0, a, 7);

    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_rdy", rdy, 1'b0);
    chk("clr_o", o, 64'h0);
    n = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) begin
        clr = 1'b1; we = 1'b1; sel = 4'hF; wa = 3'd0; wd = 32'h12345678;
      end else begin
        clr = 1'b0; we = 1'b0;
      end
      @(posedge clk); #1;
      if (rdy) break;
      n++;
    end
    clr = 1'b0; we = 1'b0;
    chk("clr_len", n, 8);
    for (int k = 0; k < 8; k++) mdl[k] = CV;
    read_all("clr_rd");

    #2 rst = 1'b1;
    #1;
    chk("arst_idle_o", o, 64'h0);
    chk("arst_idle_rdy", rdy, 1'b0);
    reset_sweep("arst1");

    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sw_o", o, 64'h0);
    chk("arst_sw_rdy", rdy, 1'b0);
    reset_sweep("arst2");
    read_all("arst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
